// File: rtl/ram_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : ram_access_arbiter
// Brief   : Round-robin two-port arbiter that sequences single-byte accesses
//           onto an async SRAM with a fixed CE window and one recovery cycle.
// Revision: 1.0
// ============================================================================
module ram_access_arbiter #(
    parameter int pRamAdrsWidth = 19,
    parameter int pRamDqWidth   = 8,
    parameter int pAccessCycle  = 4
) (
    input  logic                     iMemClk,
    input  logic                     iRst,
    input  logic                     iReq0,
    input  logic [pRamAdrsWidth-1:0] iAdrs0,
    input  logic [pRamDqWidth-1:0]   iWd0,
    input  logic                     iCmd0,
    input  logic                     iReq1,
    input  logic [pRamAdrsWidth-1:0] iAdrs1,
    input  logic [pRamDqWidth-1:0]   iWd1,
    input  logic                     iCmd1,
    output logic                     oAck0,
    output logic                     oAck1,
    output logic [pRamDqWidth-1:0]   oRd0,
    output logic [pRamDqWidth-1:0]   oRd1,
    output logic                     oRVd0,
    output logic                     oRVd1,
    output logic                     oRdErr,
    output logic                     oBusy,
    output logic [pRamAdrsWidth-1:0] oRamAdrs,
    output logic [pRamDqWidth-1:0]   oRamWd,
    output logic                     oRamCE,
    output logic                     oRamCmd,
    input  logic [pRamDqWidth-1:0]   iRamRd,
    input  logic                     iRamREd
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RECOVER = 2'd2
    } state_t;

    localparam logic [3:0] c_LAST_CNT = 4'(pAccessCycle - 1);

    state_t                   r_state;
    state_t                   w_nextState;
    logic [3:0]               r_cnt;
    logic                     r_lastGrant;
    logic                     r_owner;
    logic                     r_cmd;
    logic [pRamAdrsWidth-1:0] r_adrs;
    logic [pRamDqWidth-1:0]   r_wd;
    logic                     w_grant;
    logic                     w_winner;
    logic                     w_lastCycle;

    always_ff @(posedge iMemClk) begin
        if (iRst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_grant     = 1'b0;
        w_winner    = 1'b0;
        w_lastCycle = (r_state == ACCESS) && (r_cnt == c_LAST_CNT);
        // A tie goes to the port that was not granted last time
        if (iReq0 && iReq1) begin
            w_winner = ~r_lastGrant;
        end else begin
            w_winner = iReq1;
        end
        case (r_state)
            IDLE: begin
                if (iReq0 || iReq1) begin
                    w_grant     = 1'b1;
                    w_nextState = ACCESS;
                end
            end
            ACCESS: begin
                if (w_lastCycle) begin
                    w_nextState = RECOVER;
                end
            end
            RECOVER: w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge iMemClk) begin
        if (iRst) begin
            r_cnt       <= 4'd0;
            r_lastGrant <= 1'b1;
            r_owner     <= 1'b0;
            r_cmd       <= 1'b1;
            r_adrs      <= '0;
            r_wd        <= '0;
            oAck0       <= 1'b0;
            oAck1       <= 1'b0;
            oRVd0       <= 1'b0;
            oRVd1       <= 1'b0;
            oRd0        <= '0;
            oRd1        <= '0;
            oRdErr      <= 1'b0;
        end else begin
            oAck0 <= w_grant & ~w_winner;
            oAck1 <= w_grant & w_winner;
            oRVd0 <= 1'b0;
            oRVd1 <= 1'b0;

            if ((r_state == ACCESS) && !w_lastCycle) begin
                r_cnt <= r_cnt + 4'd1;
            end else begin
                r_cnt <= 4'd0;
            end

            if (w_grant) begin
                r_lastGrant <= w_winner;
                r_owner     <= w_winner;
                r_adrs      <= w_winner ? iAdrs1 : iAdrs0;
                r_wd        <= w_winner ? iWd1   : iWd0;
                r_cmd       <= w_winner ? iCmd1  : iCmd0;
            end

            // Read data is captured on the edge that closes the CE window
            if (w_lastCycle && r_cmd) begin
                if (r_owner) begin
                    oRd1  <= iRamRd;
                    oRVd1 <= 1'b1;
                end else begin
                    oRd0  <= iRamRd;
                    oRVd0 <= 1'b1;
                end
                if (!iRamREd) begin
                    oRdErr <= 1'b1;
                end
            end
        end
    end

    assign oBusy    = (r_state != IDLE);
    assign oRamCE   = (r_state != ACCESS);
    assign oRamCmd  = (r_state == ACCESS) ? r_cmd : 1'b1;
    assign oRamAdrs = r_adrs;
    assign oRamWd   = r_wd;

endmodule
`default_nettype wire

// File: tb/tb_ram_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_ram_access_arbiter
// Brief   : Self-checking bench for ram_access_arbiter against a
//           transaction-level model of grants, access windows and read returns.
// Revision: 1.0
// ============================================================================
module tb_ram_access_arbiter;

    localparam int N = 4;

    typedef struct packed {
        logic [18:0] adrs;
        logic [7:0]  wd;
        logic        cmd;
    } rq_t;

    logic        iMemClk = 1'b0;
    logic        iRst    = 1'b1;
    logic        iReq0 = 1'b0, iReq1 = 1'b0, iCmd0 = 1'b1, iCmd1 = 1'b1;
    logic [18:0] iAdrs0 = '0, iAdrs1 = '0;
    logic [7:0]  iWd0 = '0, iWd1 = '0, iRamRd = '0;
    logic        iRamREd = 1'b1;
    logic        oAck0, oAck1, oRVd0, oRVd1, oRdErr, oBusy, oRamCE, oRamCmd;
    logic [7:0]  oRd0, oRd1, oRamWd;
    logic [18:0] oRamAdrs;

    logic        bReq = 1'b0, bCmd = 1'b1;
    logic [18:0] bAdrs = '0;
    logic [7:0]  bWd = '0;
    logic        bAck0, bAck1, bRVd0, bRVd1, bRdErr, bBusy, bRamCE, bRamCmd;
    logic [7:0]  bRd0, bRd1, bRamWd;
    logic [18:0] bRamAdrs;

    always #5 iMemClk = ~iMemClk;

    ram_access_arbiter #(.pRamAdrsWidth(19), .pRamDqWidth(8), .pAccessCycle(N)) u_dut (
        .iMemClk(iMemClk), .iRst(iRst),
        .iReq0(iReq0), .iAdrs0(iAdrs0), .iWd0(iWd0), .iCmd0(iCmd0),
        .iReq1(iReq1), .iAdrs1(iAdrs1), .iWd1(iWd1), .iCmd1(iCmd1),
        .oAck0(oAck0), .oAck1(oAck1), .oRd0(oRd0), .oRd1(oRd1),
        .oRVd0(oRVd0), .oRVd1(oRVd1), .oRdErr(oRdErr), .oBusy(oBusy),
        .oRamAdrs(oRamAdrs), .oRamWd(oRamWd), .oRamCE(oRamCE), .oRamCmd(oRamCmd),
        .iRamRd(iRamRd), .iRamREd(iRamREd)
    );

    ram_access_arbiter #(.pRamAdrsWidth(19), .pRamDqWidth(8), .pAccessCycle(8)) u_dut8 (
        .iMemClk(iMemClk), .iRst(iRst),
        .iReq0(bReq), .iAdrs0(bAdrs), .iWd0(bWd), .iCmd0(bCmd),
        .iReq1(1'b0), .iAdrs1(19'h0), .iWd1(8'h0), .iCmd1(1'b1),
        .oAck0(bAck0), .oAck1(bAck1), .oRd0(bRd0), .oRd1(bRd1),
        .oRVd0(bRVd0), .oRVd1(bRVd1), .oRdErr(bRdErr), .oBusy(bBusy),
        .oRamAdrs(bRamAdrs), .oRamWd(bRamWd), .oRamCE(bRamCE), .oRamCmd(bRamCmd),
        .iRamRd(8'h00), .iRamREd(1'b1)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Transaction-level reference state
    bit          mActive = 1'b0;
    int          mG      = 0;
    bit          mPort   = 1'b0;
    bit          mLast   = 1'b1;
    bit          mCmd    = 1'b1;
    logic [18:0] mAdrs   = '0;
    logic [7:0]  mWd     = '0;
    logic [7:0]  mRd0 = '0, mRd1 = '0;
    bit          mErr    = 1'b0;
    logic [7:0]  refmem [int];

    rq_t q0[$];
    rq_t q1[$];
    int  hold0 = 0, hold1 = 0, gapMax = 0;
    bit  rstNext = 1'b1, errInject = 1'b0, errRate = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [7:0] memval(input logic [18:0] a);
        if (refmem.exists(int'(a))) return refmem[int'(a)];
        return 8'h00;
    endfunction

    function automatic logic [18:0] randAdrs();
        case ($urandom_range(0, 3))
            0:       return 19'h7FFFF;
            1:       return 19'($urandom);
            default: return 19'($urandom_range(0, 15));
        endcase
    endfunction

    task automatic step();
        bit ea0, ea1, ev0, ev1, w, inAcc, inRec, lastNext;
        rq_t r;
        ea0 = 0; ea1 = 0; ev0 = 0; ev1 = 0;
        @(posedge iMemClk);
        cyc++;
        if (iRst) begin
            mActive = 0; mLast = 1; mCmd = 1; mAdrs = '0; mWd = '0;
            mRd0 = '0; mRd1 = '0; mErr = 0;
        end else begin
            if (mActive && mCmd && cyc == mG + N) begin
                if (mPort) begin mRd1 = memval(mAdrs); ev1 = 1; end
                else       begin mRd0 = memval(mAdrs); ev0 = 1; end
                if (!iRamREd) mErr = 1;
            end
            if (!mActive && (iReq0 || iReq1)) begin
                w       = (iReq0 && iReq1) ? !mLast : iReq1;
                mActive = 1; mG = cyc; mPort = w; mLast = w;
                mAdrs   = w ? iAdrs1 : iAdrs0;
                mWd     = w ? iWd1   : iWd0;
                mCmd    = w ? iCmd1  : iCmd0;
                if (w) ea1 = 1; else ea0 = 1;
                if (!mCmd) refmem[int'(mAdrs)] = mWd;
            end else if (mActive && cyc == mG + N + 1) begin
                mActive = 0;
            end
        end
        #1;
        inAcc = mActive && (cyc >= mG) && (cyc <= mG + N - 1);
        inRec = mActive && (cyc == mG + N);
        chk("ack0", oAck0, ea0);
        chk("ack1", oAck1, ea1);
        chk("rvd0", oRVd0, ev0);
        chk("rvd1", oRVd1, ev1);
        chk("rd0", oRd0, mRd0);
        chk("rd1", oRd1, mRd1);
        chk("rdErr", oRdErr, mErr);
        chk("busy", oBusy, inAcc | inRec);
        chk("ramCE", oRamCE, !inAcc);
        chk("ramCmd", oRamCmd, inAcc ? mCmd : 1'b1);
        chk("ramAdrs", oRamAdrs, mAdrs);
        chk("ramWd", oRamWd, mWd);

        iRst = rstNext;
        if (iReq0 && ea0) begin iReq0 = 0; hold0 = cyc + 1 + $urandom_range(0, gapMax); end
        if (iReq1 && ea1) begin iReq1 = 0; hold1 = cyc + 1 + $urandom_range(0, gapMax); end
        if (!iReq0 && q0.size() > 0 && cyc >= hold0) begin
            r = q0.pop_front();
            iReq0 = 1; iAdrs0 = r.adrs; iWd0 = r.wd; iCmd0 = r.cmd;
        end
        if (!iReq1 && q1.size() > 0 && cyc >= hold1) begin
            r = q1.pop_front();
            iReq1 = 1; iAdrs1 = r.adrs; iWd1 = r.wd; iCmd1 = r.cmd;
        end
        lastNext = mActive && mCmd && (cyc + 1 == mG + N);
        iRamRd   = lastNext ? memval(mAdrs) : 8'($urandom);
        if (lastNext) iRamREd = errInject ? 1'b0 : (errRate ? ($urandom_range(0, 7) != 0) : 1'b1);
        else          iRamREd = 1'($urandom_range(0, 1));
    endtask

    task automatic drain(input int budget);
        int k = 0;
        while ((q0.size() > 0 || q1.size() > 0 || iReq0 || iReq1 || mActive) && k < budget) begin
            step();
            k++;
        end
        chk("drain_timeout", k < budget, 1'b1);
    endtask

    initial begin
        int k;
        // Reset state
        rstNext = 1;
        repeat (3) step();
        chk("rst_dut8_ce", bRamCE, 1'b1);
        rstNext = 0;
        step();

        // Port0 write then read back
        q0.push_back(rq_t'{19'h00010, 8'hA5, 1'b0});
        q0.push_back(rq_t'{19'h00010, 8'h00, 1'b1});
        drain(60);
        chk("t1_rd0", oRd0, 8'hA5);

        // Simultaneous reads from both ports alternate
        repeat (2) begin
            q0.push_back(rq_t'{19'h00001, 8'h11, 1'b1});
            q1.push_back(rq_t'{19'h00002, 8'h22, 1'b1});
        end
        drain(80);

        // Port1 streaming alone
        repeat (4) q1.push_back(rq_t'{randAdrs(), 8'($urandom), 1'($urandom_range(0, 1))});
        drain(80);
        chk("t3_noerr", oRdErr, 1'b0);

        // Read error at top address is sticky
        errInject = 1;
        q1.push_back(rq_t'{19'h7FFFF, 8'h00, 1'b1});
        drain(40);
        errInject = 0;
        repeat (5) step();
        chk("t5_err_sticky", oRdErr, 1'b1);

        // Reset in the middle of a read access
        q0.push_back(rq_t'{19'h00123, 8'h00, 1'b1});
        k = 0;
        while (!(mActive && mCmd && cyc == mG + 1) && k < 50) begin step(); k++; end
        chk("t4_reach", k < 50, 1'b1);
        rstNext = 1;
        step();
        rstNext = 0;
        repeat (N + 3) step();
        chk("t4_err_clr", oRdErr, 1'b0);
        q1.push_back(rq_t'{19'h00010, 8'h00, 1'b1});
        drain(40);

        // Randomized traffic
        errRate = 1;
        gapMax  = 3;
        for (int i = 0; i < 250; i++) begin
            if ($urandom_range(0, 1) == 0) q0.push_back(rq_t'{randAdrs(), 8'($urandom), 1'($urandom_range(0, 1))});
            else                           q1.push_back(rq_t'{randAdrs(), 8'($urandom), 1'($urandom_range(0, 1))});
        end
        drain(5000);

        // Longer access window on the second instance
        bReq = 1; bCmd = 0; bAdrs = 19'h00000; bWd = 8'h3C;
        step();
        chk("t6_ack", bAck0, 1'b1);
        bReq = 0;
        for (int j = 0; j < 8; j++) begin
            chk("t6_ce", bRamCE, 1'b0);
            chk("t6_cmd", bRamCmd, 1'b0);
            chk("t6_wd", bRamWd, 8'h3C);
            step();
        end
        chk("t6_rec_ce", bRamCE, 1'b1);
        chk("t6_rec_cmd", bRamCmd, 1'b1);
        chk("t6_rec_adrs", bRamAdrs, 19'h00000);
        chk("t6_rec_busy", bBusy, 1'b1);
        step();
        chk("t6_idle_busy", bBusy, 1'b0);
        chk("t6_idle_ce", bRamCE, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
